// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared types and constants for the registered ALU.
//   - alu_op_e          : 3-bit opcode encoding (000..111)
//   - ALU_DEFAULT_WIDTH : default operand/result width
//   - alu_flags_t       : packed status flags {carry, zero, negative, overflow}
//   - alu_is_ext_op     : helper telling whether an opcode is one of the
//                         optional extended operations (XOR/SHL/SHR)
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_DEFAULT_WIDTH = 8;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_NOT = 3'b100,
        OP_XOR = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic carry;
        logic zero;
        logic negative;
        logic overflow;
    } alu_flags_t;

    function automatic logic alu_is_ext_op(input alu_op_e op);
        return (op == OP_XOR) || (op == OP_SHL) || (op == OP_SHR);
    endfunction

endpackage

// File: rtl/alu_if.sv
// -----------------------------------------------------------------------------
// alu_if
//   Operand/result bundle between the execute-stage controller and the ALU.
//   Request side : in_valid, A, B, opcode
//   Response side: out_valid, result, carry, zero, negative, overflow
//   Modports:
//     master - controller (drives requests, observes results)
//     slave  - ALU        (consumes requests, drives results)
// -----------------------------------------------------------------------------
interface alu_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_DEFAULT_WIDTH
) ();

    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       opcode;

    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             negative;
    logic             overflow;

    modport master (
        output in_valid, A, B, opcode,
        input  out_valid, result, carry, zero, negative, overflow
    );

    modport slave (
        input  in_valid, A, B, opcode,
        output out_valid, result, carry, zero, negative, overflow
    );

endinterface

// File: rtl/alu_addsub.sv
// -----------------------------------------------------------------------------
// alu_addsub
//   Shared WIDTH-bit adder used for both ADD and SUB. Subtraction is done as
//   a + ~b + 1, so one carry chain serves both operations.
//   Ports:
//     a, b      : operands
//     sub       : 1 = subtract (invert b, carry-in 1), 0 = add
//     sum       : WIDTH-bit result (modulo 2^WIDTH)
//     carry_out : raw carry out of the MSB (for SUB this is NOT-borrow)
//     overflow  : two's-complement overflow of the performed operation
// -----------------------------------------------------------------------------
module alu_addsub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_full;

    // Conditional inversion of b, bit by bit.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_binv
            assign b_eff[gi] = b[gi] ^ sub;
        end
    endgenerate

    assign sum_full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    assign sum       = sum_full[WIDTH-1:0];
    assign carry_out = sum_full[WIDTH];

    // With the effective addend, both ADD and SUB overflow when the two
    // addends share a sign and the sum's sign differs from it.
    assign overflow  = (a[WIDTH-1] == b_eff[WIDTH-1]) &&
                       (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
//   Registered WIDTH-bit arithmetic/logic unit (execute stage). One operation
//   accepted per clock when in_valid is high; result and flags are registered
//   and presented with out_valid one cycle later. With in_valid low the
//   result/flags hold and out_valid drops. Reset is asynchronous, active-low,
//   and clears all outputs immediately.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : alu_if.slave (in_valid, A, B, opcode -> out_valid, result,
//             carry, zero, negative, overflow)
//   Configuration macro:
//     ALU_EXT_OPS_EN : when defined, opcodes 101/110/111 implement XOR, SHL
//                      and SHR. When undefined those opcodes return result 0
//                      with zero=1 and the XOR/shift logic is not built.
// -----------------------------------------------------------------------------
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_DEFAULT_WIDTH
) (
    input  logic  clk,
    input  logic  rst_n,
    alu_if.slave  bus
);

    alu_op_e          op;
    logic             sub_sel;
    logic [WIDTH-1:0] as_sum;
    logic             as_carry;
    logic             as_overflow;

    logic [WIDTH-1:0] result_next;
    alu_flags_t       flags_next;
    logic             carry_next;
    logic             overflow_next;

    logic [WIDTH-1:0] result_reg;
    alu_flags_t       flags_reg;
    logic             out_valid_reg;

    assign op      = alu_op_e'(bus.opcode);
    assign sub_sel = (op == OP_SUB);

    alu_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a         (bus.A),
        .b         (bus.B),
        .sub       (sub_sel),
        .sum       (as_sum),
        .carry_out (as_carry),
        .overflow  (as_overflow)
    );

    // Opcode mux. Defaults give result 0 / carry 0 / overflow 0, which is
    // also what the extended opcodes produce when they are not built.
    always_comb begin
        result_next   = '0;
        carry_next    = 1'b0;
        overflow_next = 1'b0;
        case (op)
            OP_ADD: begin
                result_next   = as_sum;
                carry_next    = as_carry;
                overflow_next = as_overflow;
            end
            OP_SUB: begin
                // Carry out of a + ~b + 1 is set when no borrow occurred.
                result_next   = as_sum;
                carry_next    = ~as_carry;
                overflow_next = as_overflow;
            end
            OP_AND: result_next = bus.A & bus.B;
            OP_OR:  result_next = bus.A | bus.B;
            OP_NOT: result_next = ~bus.A;
`ifdef ALU_EXT_OPS_EN
            OP_XOR: result_next = bus.A ^ bus.B;
            OP_SHL: begin
                result_next = {bus.A[WIDTH-2:0], 1'b0};
                carry_next  = bus.A[WIDTH-1];
            end
            OP_SHR: begin
                result_next = {1'b0, bus.A[WIDTH-1:1]};
                carry_next  = bus.A[0];
            end
`endif
            default: begin
                result_next   = '0;
                carry_next    = 1'b0;
                overflow_next = 1'b0;
            end
        endcase
    end

    always_comb begin
        flags_next          = '0;
        flags_next.carry    = carry_next;
        flags_next.zero     = (result_next == '0);
        flags_next.negative = result_next[WIDTH-1];
        flags_next.overflow = overflow_next;
    end

    // Output registers: capture only on accepted operations; out_valid is a
    // one-cycle echo of in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg    <= '0;
            flags_reg     <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                result_reg <= result_next;
                flags_reg  <= flags_next;
            end
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.result    = result_reg;
    assign bus.carry     = flags_reg.carry;
    assign bus.zero      = flags_reg.zero;
    assign bus.negative  = flags_reg.negative;
    assign bus.overflow  = flags_reg.overflow;

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu
//   Scoreboard bench for alu (WIDTH = 8). Expected results are computed by a
//   reference model and queued when an operation is driven; a monitor pops
//   and compares them when the DUT reports out_valid, and checks hold/reset
//   behaviour on idle cycles. Honours ALU_EXT_OPS_EN like the design.
// -----------------------------------------------------------------------------
module tb_alu;

    localparam int W = 8;

    typedef struct packed {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         c;
        logic         z;
        logic         n;
        logic         v;
    } exp_t;

    logic clk;
    logic rst_n;

    alu_if #(.WIDTH(W)) bus ();

    alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    exp_t exp_q[$];

    logic [W-1:0] hold_res;
    logic [3:0]   hold_flags;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t       e;
        logic [W:0] wide;
        e     = '0;
        e.op  = op;
        e.a   = a;
        e.b   = b;
        case (op)
            3'd0: begin
                wide  = {1'b0, a} + {1'b0, b};
                e.res = wide[W-1:0];
                e.c   = wide[W];
                e.v   = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            3'd1: begin
                e.res = a - b;
                e.c   = (a < b);
                e.v   = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            3'd2: e.res = a & b;
            3'd3: e.res = a | b;
            3'd4: e.res = ~a;
`ifdef ALU_EXT_OPS_EN
            3'd5: e.res = a ^ b;
            3'd6: begin e.res = a << 1; e.c = a[W-1]; end
            3'd7: begin e.res = a >> 1; e.c = a[0];   end
`endif
            default: e.res = '0;
        endcase
        e.z = (e.res == 0);
        e.n = e.res[W-1];
        return e;
    endfunction

    // Drive one operation at the falling edge and queue its expected result.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.A        = a;
        bus.B        = b;
        exp_q.push_back(model(op, a, b));
    endtask

    // Idle cycle with scrambled operands; outputs must not react.
    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.opcode   = 3'($urandom_range(0, 7));
        bus.A        = W'($urandom);
        bus.B        = W'($urandom);
    endtask

    // Monitor: decide at the rising edge whether a capture happens, then
    // inspect the outputs 1 time unit later.
    always @(posedge clk) begin
        logic cap;
        exp_t e;
        cap = bus.in_valid && rst_n;
        #1;
        if (!rst_n) begin
            check("rst_valid", 32'(bus.out_valid), 0);
            check("rst_result", 32'(bus.result), 0);
            check("rst_flags", {bus.carry, bus.zero, bus.negative, bus.overflow}, 0);
            hold_res   = '0;
            hold_flags = '0;
        end else if (cap) begin
            check("out_valid", 32'(bus.out_valid), 1);
            if (exp_q.size() == 0) begin
                check("pending", 32'(exp_q.size()), 1);
            end else begin
                e = exp_q.pop_front();
                $display("txn op=%0d A=0x%02h B=0x%02h -> result=0x%02h c=%0b z=%0b n=%0b v=%0b",
                         e.op, e.a, e.b, bus.result, bus.carry, bus.zero, bus.negative, bus.overflow);
                check("result", 32'(bus.result), 32'(e.res));
                check("carry", 32'(bus.carry), 32'(e.c));
                check("zero", 32'(bus.zero), 32'(e.z));
                check("negative", 32'(bus.negative), 32'(e.n));
                check("overflow", 32'(bus.overflow), 32'(e.v));
                hold_res   = e.res;
                hold_flags = {e.c, e.z, e.n, e.v};
            end
        end else begin
            check("idle_valid", 32'(bus.out_valid), 0);
            check("hold_result", 32'(bus.result), 32'(hold_res));
            check("hold_flags", {bus.carry, bus.zero, bus.negative, bus.overflow}, 32'(hold_flags));
        end
    end

    initial begin
        hold_res     = '0;
        hold_flags   = '0;
        // Reset held with a valid ADD 15+10 pending on the inputs.
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.opcode   = 3'd0;
        bus.A        = 8'd15;
        bus.B        = 8'd10;
        repeat (3) @(posedge clk);
        #2;
        check("reset_result", 32'(bus.result), 0);
        check("reset_valid", 32'(bus.out_valid), 0);

        // Release: the first edge with rst_n=1 captures 15+10 = 25.
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(model(3'd0, 8'd15, 8'd10));

        // Five back-to-back basic ops: 25, 5, 10, 15, 240.
        for (int i = 0; i < 5; i++) issue(3'(i), 8'd15, 8'd10);
        for (int i = 0; i < 3; i++) idle();

        // Arithmetic boundaries.
        issue(3'd0, 8'd255, 8'd1);
        issue(3'd0, 8'd127, 8'd1);
        idle();
        issue(3'd1, 8'd10, 8'd15);
        idle();

        // Extended opcodes (model follows the same build option).
        issue(3'd5, 8'd15, 8'd10);
        issue(3'd6, 8'h81, 8'h00);
        issue(3'd7, 8'h81, 8'h00);
        idle();

        // Random mix of operations and idle cycles.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            else issue(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
        end

        // Mid-cycle asynchronous reset after a nonzero result.
        issue(3'd0, 8'd100, 8'd50);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_result", 32'(bus.result), 0);
        check("async_valid", 32'(bus.out_valid), 0);
        check("async_flags", {bus.carry, bus.zero, bus.negative, bus.overflow}, 0);
        repeat (2) @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;

        // Stream resumes after reset.
        issue(3'd0, 8'd15, 8'd10);
        issue(3'd1, 8'd15, 8'd10);
        issue(3'd4, 8'h0f, 8'h00);
        issue(3'd3, 8'h00, 8'h00);
        issue(3'd1, 8'h80, 8'h01);
        for (int i = 0; i < 3; i++) idle();

        check("queue_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
